// File: rtl/trig_rom_arbiter.sv
// Round-robin arbiter sharing one sin/cos ROM pair between several requesters.
// Folds angles of 360 and above back into the table range and tags each read so its result returns to the right owner.
module trig_rom_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ANGLE_W     = 9,
  parameter int TRIG_W      = 11,
  parameter int ROM_LATENCY = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_REQ-1:0]          req_in,
  input  logic [NUM_REQ*ANGLE_W-1:0]  angle_in,
  output logic [NUM_REQ-1:0]          gnt_out,
  output logic [ANGLE_W-1:0]          rom_addr_out,
  input  logic signed [TRIG_W-1:0]    rom_cos_in,
  input  logic signed [TRIG_W-1:0]    rom_sin_in,
  output logic [NUM_REQ-1:0]          valid_out,
  output logic signed [TRIG_W-1:0]    cos_out,
  output logic signed [TRIG_W-1:0]    sin_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                ptr;
  logic [PTR_W-1:0]                next_ptr;
  logic [PTR_W:0]                  scan;
  logic                            found;
  logic [ANGLE_W-1:0]              gnt_angle;
  logic [ANGLE_W-1:0]              wrapped_angle;
  logic [ROM_LATENCY:0][NUM_REQ-1:0] tag;

  // Search upward from the pointer, wrapping, and grant the first live request.
  always_comb begin
    gnt_out = '0;
    found   = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_REQ))
        scan = scan - (PTR_W+1)'(NUM_REQ);
      if (!found && req_in[scan[PTR_W-1:0]]) begin
        gnt_out[scan[PTR_W-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
    if (rst_in)
      gnt_out = '0;
  end

  always_comb begin
    gnt_angle = '0;
    next_ptr  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_out[i]) begin
        gnt_angle = angle_in[i*ANGLE_W +: ANGLE_W];
        next_ptr  = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  // A 9-bit angle never exceeds 511, so one subtraction brings it into 0..359.
  assign wrapped_angle = (gnt_angle >= ANGLE_W'(360)) ? gnt_angle - ANGLE_W'(360) : gnt_angle;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr          <= '0;
      rom_addr_out <= '0;
      tag          <= '0;
      valid_out    <= '0;
      cos_out      <= '0;
      sin_out      <= '0;
    end else begin
      ptr <= next_ptr;
      if (|gnt_out)
        rom_addr_out <= wrapped_angle;
      tag       <= {tag[ROM_LATENCY-1:0], gnt_out};
      valid_out <= tag[ROM_LATENCY];
      // The last tag stage lines up with ROM data for that grant.
      if (|tag[ROM_LATENCY]) begin
        cos_out <= rom_cos_in;
        sin_out <= rom_sin_in;
      end
    end
  end

endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Directed bench for trig_rom_arbiter with a two-cycle ROM model and a queue-based reference.
// Every negedge the reference predicts grant, address, valid pulse and result.
module tb_trig_rom_arbiter;

  localparam int N = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [1:0]         req = 2'b00;
  logic [8:0]         ang0 = '0;
  logic [8:0]         ang1 = '0;
  logic [17:0]        angle_in;
  logic [1:0]         gnt;
  logic [8:0]         rom_addr;
  logic signed [10:0] rom_cos;
  logic signed [10:0] rom_sin;
  logic [1:0]         valid;
  logic signed [10:0] cos_o;
  logic signed [10:0] sin_o;

  logic signed [10:0] p1_cos, p2_cos, p1_sin, p2_sin;

  int cos_tab [360];
  int sin_tab [360];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int r;
    int ang;
    int due;
  } ent_t;

  ent_t q[$];
  int   mptr  = 0;
  int   maddr = 0;
  int   mcos  = 0;
  int   msin  = 0;
  int   mg;
  int   mv;
  int   ma;

  assign angle_in = {ang1, ang0};

  trig_rom_arbiter dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .req_in      (req),
    .angle_in    (angle_in),
    .gnt_out     (gnt),
    .rom_addr_out(rom_addr),
    .rom_cos_in  (rom_cos),
    .rom_sin_in  (rom_sin),
    .valid_out   (valid),
    .cos_out     (cos_o),
    .sin_out     (sin_o)
  );

  initial forever #5 clk = ~clk;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Two-register ROM: data for an address is on douta two edges later.
  always @(posedge clk) begin
    p1_cos <= 11'(cos_tab[rom_addr]);
    p1_sin <= 11'(sin_tab[rom_addr]);
    p2_cos <= p1_cos;
    p2_sin <= p1_sin;
    cyc    <= cyc + 1;
  end
  assign rom_cos = p2_cos;
  assign rom_sin = p2_sin;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: round-robin pick, angle mod 360, result three edges after the grant.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mptr  = 0;
      maddr = 0;
      mcos  = 0;
      msin  = 0;
      checkOutput("rst gnt", int'(gnt), 0);
      checkOutput("rst valid", int'(valid), 0);
      checkOutput("rst addr", int'(rom_addr), 0);
      checkOutput("rst cos", int'(cos_o), 0);
      checkOutput("rst sin", int'(sin_o), 0);
    end else begin
      checkOutput("model addr", int'(rom_addr), maddr);
      mv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        mv   = 1 << q[0].r;
        mcos = cos_tab[q[0].ang];
        msin = sin_tab[q[0].ang];
        void'(q.pop_front());
      end
      checkOutput("model valid", int'(valid), mv);
      checkOutput("model cos", int'(cos_o), mcos);
      checkOutput("model sin", int'(sin_o), msin);
      mg = -1;
      for (int k = 0; k < N; k++)
        if (mg < 0 && req[(mptr + k) % N]) mg = (mptr + k) % N;
      checkOutput("model gnt", int'(gnt), (mg < 0) ? 0 : (1 << mg));
      if (mg >= 0) begin
        ma = (mg == 0) ? int'(ang0) : int'(ang1);
        ma = ma % 360;
        q.push_back('{mg, ma, cyc + 4});
        maddr = ma;
        mptr  = (mg + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated read by requester r, checked against hand-computed values.
  task automatic applyStimulus(input int r, input int ang, input int ecos, input int esin, input int eaddr);
    if (r == 0) ang0 = 9'(ang); else ang1 = 9'(ang);
    req = 2'(1 << r);
    #1;
    checkOutput("single gnt", int'(gnt), 1 << r);
    tick();
    req = 2'b00;
    checkOutput("single addr", int'(rom_addr), eaddr);
    tick();
    tick();
    checkOutput("single early valid", int'(valid), 0);
    tick();
    checkOutput("single valid", int'(valid), 1 << r);
    checkOutput("single cos", int'(cos_o), ecos);
    checkOutput("single sin", int'(sin_o), esin);
    tick();
    checkOutput("single valid drop", int'(valid), 0);
    checkOutput("single cos hold", int'(cos_o), ecos);
  endtask

  int bb_cos [4] = '{512, 443, 256, 0};

  initial begin
    for (int a = 0; a < 360; a++) begin
      cos_tab[a] = rnd(512.0 * $cos(a * 3.14159265358979 / 180.0));
      sin_tab[a] = rnd(512.0 * $sin(a * 3.14159265358979 / 180.0));
    end
    #1 rst = 1'b1;
    req = 2'b11;
    tick();
    tick();
    checkOutput("reset gnt", int'(gnt), 0);
    checkOutput("reset valid", int'(valid), 0);
    checkOutput("reset addr", int'(rom_addr), 0);
    rst = 1'b0;
    #1;
    checkOutput("first gnt after reset", int'(gnt), 1);
    req = 2'b00;
    tick();
    checkOutput("idle gnt", int'(gnt), 0);

    applyStimulus(0, 90, 0, 512, 90);
    applyStimulus(1, 450, 0, 512, 90);
    applyStimulus(1, 359, 512, -9, 359);
    applyStimulus(1, 360, 512, 0, 0);

    // Contention: pointer is 0 here, so grants run 0,1,0,1,...
    ang0 = 9'd0;
    ang1 = 9'd180;
    req  = 2'b11;
    #1;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 8) checkOutput("contend gnt", int'(gnt), ((k - 1) % 2 == 1) ? 2 : 1);
      tick();
      if (k == 8) req = 2'b00;
      if (k >= 4) begin
        checkOutput("contend valid", int'(valid), ((k - 4) % 2 == 1) ? 2 : 1);
        checkOutput("contend cos", int'(cos_o), ((k - 4) % 2 == 1) ? -512 : 512);
      end
    end

    // Back-to-back reads from requester 0 alone.
    ang0 = 9'd0;
    req  = 2'b01;
    #1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 3) ang0 = 9'(30 * k);
      if (k == 4) req = 2'b00;
      if (k >= 4) begin
        checkOutput("b2b valid", int'(valid), 1);
        checkOutput("b2b cos", int'(cos_o), bb_cos[k - 4]);
      end
    end
    tick();
    checkOutput("b2b valid end", int'(valid), 0);

    // Reset one cycle after a grant to requester 0 (pointer then at 1).
    ang0 = 9'd45;
    req  = 2'b01;
    #1;
    tick();
    req = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", int'(valid), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("midrst no pulse", int'(valid), 0);
    end
    req = 2'b11;
    #1;
    checkOutput("midrst ptr 0", int'(gnt), 1);
    req = 2'b00;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trig_rom_arbiter.md
Name: trig_rom_arbiter

Overview:
- Shares one sine/cosine ROM pair (360-entry, 11-bit signed, scaled by 512) between several requesters: the forward-view renderer, the physics/steering update and the minimap rotation.
- Requesters present an angle and hold a request; the arbiter grants one per cycle round-robin, drives the ROM address, and returns the ROM data tagged to the granted requester.
- Sits between the requesters and the single ROM pair, so the design instantiates one trig table instead of one per consumer.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ANGLE_W, 9, angle width in degrees; 0 is the +x axis, counter-clockwise positive.
- TRIG_W, 11, signed sin/cos sample width.
- ROM_LATENCY, 2, ROM read latency in cycles from address register to valid douta (HIGH_PERFORMANCE mode).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- req_in  in  NUM_REQ  per-requester request level
- angle_in  in  NUM_REQ*ANGLE_W  packed angles; requester i occupies bits [i*ANGLE_W +: ANGLE_W]
- gnt_out  out  NUM_REQ  one-hot grant, combinational from req_in and the registered pointer
- rom_addr_out  out  ANGLE_W  registered address to both ROMs
- rom_cos_in  in  TRIG_W  cos ROM douta
- rom_sin_in  in  TRIG_W  sin ROM douta
- valid_out  out  NUM_REQ  one-hot, one-cycle pulse marking the owner of cos_out/sin_out
- cos_out  out  TRIG_W  registered signed cosine result
- sin_out  out  TRIG_W  registered signed sine result

Behaviour:
- Reset (asynchronous, active-high):
  - rom_addr_out, cos_out, sin_out, valid_out are 0.
  - Round-robin pointer is 0.
  - Tag pipeline is cleared, so reads in flight at reset never produce valid_out.
- Arbitration:
  - gnt_out selects the first asserted req_in found searching upward from the pointer, wrapping modulo NUM_REQ.
  - gnt_out is 0 when no request is asserted.
  - gnt_out is 0 while rst_in is high.
  - At most one grant per cycle.
- Handshake:
  - A requester holds req_in and its angle stable until it samples gnt_out high at a rising edge; that edge is the grant edge.
  - A requester may keep req_in high to issue back-to-back reads, one per grant.
- Pointer update: on a grant edge to requester i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Angle wrap:
  - On the grant edge, rom_addr_out is loaded with the granted angle, minus 360 if the angle is 360 or more. With ANGLE_W=9 the maximum is 511, so one subtraction suffices.
  - With no grant, rom_addr_out holds its value; the ROMs stay enabled.
- Tag pipeline:
  - A one-hot tag shift register of ROM_LATENCY+1 stages.
  - Stage 0 loads gnt_out on each edge, or zero when there is no grant.
- Latency:
  - ROM data for the grant edge E is valid after edge E+ROM_LATENCY.
  - cos_out/sin_out capture rom_cos_in/rom_sin_in at edge E+ROM_LATENCY+1, when valid_out is set to the final tag stage for one cycle.
  - Total latency is 3 cycles at defaults.
  - cos_out/sin_out hold their last value when valid_out is 0.
- Throughput:
  - One result per cycle; results return in grant order.
  - Consecutive results may belong to different requesters.
- Simultaneous requests from all requesters: grants rotate strictly; no requester waits more than NUM_REQ-1 cycles.
- A request dropped before being granted is simply not served; no state is left behind.
- Reset mid-stream: pending and in-flight reads are lost. After release, the first grant goes to the lowest-indexed asserted requester.

Test Plan:
- Reset: hold rst_in high while req_in=2'b11, then release. gnt_out=0 during reset; all outputs 0. The first grant after release goes to requester 0.
- Single read: requester 0 requests angle 90 against a ROM model returning round(512·cos), round(512·sin). Grant in the same cycle; valid_out=2'b01 exactly 3 cycles after the grant edge; cos_out=0, sin_out=512.
- Wrap: requester 1 requests angle 450. rom_addr_out=90; requester 1 receives cos_out=0, sin_out=512. Angle 359 drives address 359; angle 360 drives address 0, giving cos_out=512.
- Contention: both requesters hold req high for 8 cycles with angles 0 and 180. Grants alternate 0,1,0,1,…; valid_out alternates accordingly with cos_out alternating 512 and −512.
- Back-to-back: requester 0 alone issues angles 0, 30, 60, 90 on consecutive grant edges. Four consecutive valid pulses with cos_out 512, 443, 256, 0 in order.
- Reset mid-flight: assert rst_in one cycle after a grant. No valid_out pulse ever appears for that read; the pointer returns to 0.
